nibble_serial_adder_ctrl: RTL

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract engine: one shared 4-bit adder walks the operands
// LSB nibble first and publishes the full result only when the last nibble lands.

module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e                    state_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;      // holds B' (already inverted for subtract)
    logic [NIBBLES-1:0][3:0]   res_q;
    logic [NIBBLES-1:0][3:0]   res_d;
    logic                      carry_q;
    logic [IdxW-1:0]           idx_q;
    logic                      busy_q;
    logic                      done_q;
    logic [W-1:0]              sum_q;
    logic                      cout_q;
    logic                      overflow_q;

    logic [3:0]                add_a;
    logic [3:0]                add_b;
    logic [3:0]                add_sum;
    logic                      add_cout;
    logic                      last_nib;
    logic                      overflow_d;

    four_bit_full_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

    // Full result as it will look after this edge, used for the final publish.
    always_comb begin
        add_a        = a_q[idx_q];
        add_b        = b_q[idx_q];
        res_d        = res_q;
        res_d[idx_q] = add_sum;
        overflow_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                       (res_d[NIBBLES-1][3] != a_q[NIBBLES-1][3]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    res_q   <= res_d;
                    carry_q <= add_cout;
                    if (last_nib) begin
                        idx_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        sum_q      <= res_d;
                        cout_q     <= add_cout;
                        overflow_q <= overflow_d;
                        state_q    <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule
